// File: rtl/phy_tx_stim_gen.sv
// PHY TX stimulus generator with RX loopback checker: fixed pattern table by default,
// PRBS31 word source and checker when TX_PRBS_EN is defined.
module phy_tx_stim_gen #(
    parameter int DATA_W  = 32,
    parameter int DIV     = 16,
    parameter int DEPTH   = 4,
    parameter int REPEAT  = 8,
    parameter int RST_DLY = 128
) (
    input  logic              clk_32f,
    input  logic              reset,
    input  logic              start,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_valid,
    output logic              busy,
    output logic              done,
    output logic [15:0]       word_cnt,
    output logic [15:0]       err_cnt
);

    typedef enum logic [1:0] {IDLE, HOLD, RUN, DONE} state_t;

`ifdef TX_PRBS_EN
    localparam int RUN_WORDS = REPEAT * 4;
`else
    localparam int RUN_WORDS = DEPTH * REPEAT;
`endif
    localparam logic [31:0] RUN_LEN   = 32'(RUN_WORDS);
    localparam logic [15:0] DIV_LAST  = 16'(DIV - 1);
    localparam logic [15:0] HOLD_LAST = 16'(RST_DLY - 1);

    state_t      state;
    logic        start_q;
    logic [15:0] div_cnt;
    logic [15:0] hold_cnt;
    logic [31:0] sent;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

`ifdef TX_PRBS_EN
    logic [30:0] tx_lfsr;
    logic [30:0] rx_lfsr;

    // x^31 + x^28 + 1, first generated bit lands in the word MSB
    function automatic logic [DATA_W-1:0] prbs_word(input logic [30:0] s);
        logic [30:0]       t;
        logic [DATA_W-1:0] w;
        t = s;
        w = '0;
        for (int n = 0; n < DATA_W; n++) begin
            w = {w[DATA_W-2:0], t[30] ^ t[27]};
            t = {t[29:0], t[30] ^ t[27]};
        end
        return w;
    endfunction

    function automatic logic [30:0] prbs_next(input logic [30:0] s);
        logic [30:0] t;
        t = s;
        for (int n = 0; n < DATA_W; n++) t = {t[29:0], t[30] ^ t[27]};
        return t;
    endfunction
`else
    localparam int          REPS     = (DATA_W + 31) / 32;
    localparam logic [4:0]  LAST_PTR = 5'(DEPTH - 1);

    logic [4:0] tx_ptr;
    logic [4:0] rx_ptr;

    // base word replicated across DATA_W, then rotated left by idx/4
    function automatic logic [DATA_W-1:0] pattern(input logic [4:0] idx);
        logic [31:0]        base;
        logic [REPS*32-1:0] wide;
        logic [DATA_W-1:0]  rep;
        case (idx[1:0])
            2'd0:    base = 32'hFFDD_FFDD;
            2'd1:    base = 32'hEEAA_EEAA;
            2'd2:    base = 32'hDDFF_AABB;
            default: base = 32'hCABF_FABC;
        endcase
        wide = {REPS{base}};
        rep  = wide[DATA_W-1:0];
        return (rep << idx[4:2]) | (rep >> (DATA_W - int'(idx[4:2])));
    endfunction
`endif

    always_ff @(posedge clk_32f) begin
        if (!reset) begin
            state    <= IDLE;
            start_q  <= 1'b0;
            div_cnt  <= '0;
            hold_cnt <= '0;
            sent     <= '0;
            tx_data  <= '0;
            tx_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            word_cnt <= '0;
            err_cnt  <= '0;
`ifdef TX_PRBS_EN
            tx_lfsr  <= '1;
            rx_lfsr  <= '1;
`else
            tx_ptr   <= '0;
            rx_ptr   <= '0;
`endif
        end else begin
            start_q <= start;
            case (state)
                IDLE: begin
                    if (start && !start_q) begin
                        // a zero hold delay skips HOLD so the first strobe lands DIV cycles out
                        state    <= (RST_DLY == 0) ? RUN : HOLD;
                        busy     <= 1'b1;
                        div_cnt  <= '0;
                        hold_cnt <= '0;
                        sent     <= '0;
                        word_cnt <= '0;
                        err_cnt  <= '0;
`ifdef TX_PRBS_EN
                        tx_lfsr  <= '1;
                        rx_lfsr  <= '1;
`else
                        tx_ptr   <= '0;
                        rx_ptr   <= '0;
`endif
                    end
                end
                HOLD: begin
                    if (hold_cnt == HOLD_LAST) begin
                        state   <= RUN;
                        div_cnt <= '0;
                    end else begin
                        hold_cnt <= hold_cnt + 16'd1;
                    end
                end
                RUN: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        if (sent == RUN_LEN) begin
                            tx_valid <= 1'b0;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            state    <= DONE;
                        end else begin
                            tx_valid <= 1'b1;
                            sent     <= sent + 32'd1;
                            word_cnt <= sat_inc(word_cnt);
`ifdef TX_PRBS_EN
                            tx_data  <= prbs_word(tx_lfsr);
                            tx_lfsr  <= prbs_next(tx_lfsr);
`else
                            tx_data  <= pattern(tx_ptr);
                            tx_ptr   <= (tx_ptr == LAST_PTR) ? 5'd0 : tx_ptr + 5'd1;
`endif
                        end
                    end else begin
                        div_cnt <= div_cnt + 16'd1;
                    end
                end
                DONE: begin
                    if (!start) begin
                        done  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // loopback checker keeps its own pointer, independent of the TX strobe
            if (state != IDLE && rx_valid) begin
`ifdef TX_PRBS_EN
                if (rx_data != prbs_word(rx_lfsr)) err_cnt <= sat_inc(err_cnt);
                rx_lfsr <= prbs_next(rx_lfsr);
`else
                if (rx_data != pattern(rx_ptr)) err_cnt <= sat_inc(err_cnt);
                rx_ptr <= (rx_ptr == LAST_PTR) ? 5'd0 : rx_ptr + 5'd1;
`endif
            end
        end
    end

endmodule

// File: tb/tb_phy_tx_stim_gen.sv
// Bench for phy_tx_stim_gen: default instance with delayed loopback plus a minimal-size instance.
module tb_phy_tx_stim_gen;

    localparam int DIV0 = 16, DEPTH0 = 4, REP0 = 8, DLY0 = 128;
    localparam int DIV1 = 2,  DEPTH1 = 1, REP1 = 1, DLY1 = 0;
`ifdef TX_PRBS_EN
    localparam int LEN0 = REP0 * 4, LEN1 = REP1 * 4;
`else
    localparam int LEN0 = DEPTH0 * REP0, LEN1 = DEPTH1 * REP1;
`endif
    localparam int BUD0 = DLY0 + DIV0 * (LEN0 + 2) + 20;

    logic        clk = 1'b0;
    logic        reset;
    logic        start0, start1;
    logic [31:0] tx_data0, tx_data1, rx_data0, rx_data1;
    logic        tx_valid0, tx_valid1, rx_valid0, rx_valid1;
    logic        busy0, busy1, done0, done1;
    logic [15:0] word_cnt0, word_cnt1, err_cnt0, err_cnt1;

    always #5 clk = ~clk;

    phy_tx_stim_gen #(.DATA_W(32), .DIV(DIV0), .DEPTH(DEPTH0), .REPEAT(REP0), .RST_DLY(DLY0)) u0 (
        .clk_32f(clk), .reset(reset), .start(start0),
        .tx_data(tx_data0), .tx_valid(tx_valid0),
        .rx_data(rx_data0), .rx_valid(rx_valid0),
        .busy(busy0), .done(done0), .word_cnt(word_cnt0), .err_cnt(err_cnt0));

    phy_tx_stim_gen #(.DATA_W(32), .DIV(DIV1), .DEPTH(DEPTH1), .REPEAT(REP1), .RST_DLY(DLY1)) u1 (
        .clk_32f(clk), .reset(reset), .start(start1),
        .tx_data(tx_data1), .tx_valid(tx_valid1),
        .rx_data(rx_data1), .rx_valid(rx_valid1),
        .busy(busy1), .done(done1), .word_cnt(word_cnt1), .err_cnt(err_cnt1));

    int total = 0;
    int bad   = 0;

    // PRBS31 reference bit stream: b[n] = b[n-31] ^ b[n-28], all ones before n = 0
    bit pb [0:2047];

    function automatic logic [31:0] exp_word(input int depth, input int k);
        logic [31:0] w;
`ifdef TX_PRBS_EN
        for (int j = 0; j < 32; j++) w[31-j] = pb[k*32 + j];
`else
        logic [31:0] bases [4];
        logic [63:0] t;
        int i;
        bases = '{32'hFFDDFFDD, 32'hEEAAEEAA, 32'hDDFFAABB, 32'hCABFFABC};
        i = k % depth;
        t = {bases[i%4], bases[i%4]} << (i / 4);
        w = t[63:32];
`endif
        return w;
    endfunction

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // u0 monitor / loopback state
    int          cyc = 0, sent0 = 0, last0 = 0, start_cyc0 = 0, exp_err0 = 0, cmode = 0;
    logic [15:0] prev_wc0 = '0;
    logic        pv [3];
    logic [31:0] pd [3];
    // u1 monitor state
    int          v1cnt = 0, lat1 = -1, start_cyc1 = 0;
    logic [31:0] first1 = '0;
    logic        prev_v1 = 1'b0, fall_done1 = 1'b0;

    task automatic clear_pipe();
        for (int i = 0; i < 3; i++) begin pv[i] = 1'b0; pd[i] = '0; end
        rx_valid0 = 1'b0;
        prev_wc0  = '0;
        sent0     = 0;
    endtask

    task automatic tick();
        logic [31:0] w;
        logic        nw;
        @(posedge clk); #1;
        cyc++;
        nw = tx_valid0 && (word_cnt0 != prev_wc0);
        prev_wc0 = word_cnt0;
        rx_valid0 = pv[2]; rx_data0 = pd[2];
        pv[2] = pv[1]; pd[2] = pd[1];
        pv[1] = pv[0]; pd[1] = pd[0];
        pv[0] = nw;    pd[0] = tx_data0;
        if (nw) begin
            if (sent0 == 0) check("latency", 64'(cyc - start_cyc0), 64'(DLY0 + DIV0));
            else            check("hold", 64'(cyc - last0), 64'(DIV0));
            check("word", 64'(tx_data0), 64'(exp_word(DEPTH0, sent0)));
            w = '0;
            if (cmode == 1 && (sent0 == 4 || sent0 == 16)) w = 32'h1;
            if (cmode == 2 && $urandom_range(3) == 0) w = 32'h1 << $urandom_range(31);
            if (w != 0) exp_err0++;
            pd[0] = tx_data0 ^ w;
            last0 = cyc;
            sent0++;
        end
        if (tx_valid1) begin
            v1cnt++;
            if (v1cnt == 1) begin lat1 = cyc - start_cyc1; first1 = tx_data1; end
        end
        if (prev_v1 && !tx_valid1) fall_done1 = done1;
        prev_v1 = tx_valid1;
    endtask

    task automatic launch0(input int mode);
        cmode = mode; sent0 = 0; exp_err0 = 0;
        start0 = 1'b1;
        start_cyc0 = cyc + 1;
        tick();
    endtask

    task automatic wait_done0();
        int n = 0;
        while (!done0 && n < BUD0) begin tick(); n++; end
        check("done_reached", 64'(done0), 64'd1);
    endtask

    task automatic end_checks(input string tag);
        check({tag, "_word_cnt"}, 64'(word_cnt0), 64'(LEN0));
        check({tag, "_err_cnt"}, 64'(err_cnt0), 64'(exp_err0));
        check({tag, "_busy"}, 64'(busy0), 64'd0);
        check({tag, "_words_seen"}, 64'(sent0), 64'(LEN0));
    endtask

    initial begin
        for (int n = 0; n < 2048; n++)
            pb[n] = (n >= 31 ? pb[n-31] : 1'b1) ^ (n >= 28 ? pb[n-28] : 1'b1);
        reset = 1'b0; start0 = 1'b0; start1 = 1'b0;
        rx_data0 = '0; rx_data1 = '0; rx_valid1 = 1'b0;
        clear_pipe();

        // reset held low for 8 cycles
        repeat (8) tick();
        check("rst_tx_data", 64'(tx_data0), 64'd0);
        check("rst_tx_valid", 64'(tx_valid0), 64'd0);
        check("rst_busy", 64'(busy0), 64'd0);
        check("rst_done", 64'(done0), 64'd0);
        check("rst_word_cnt", 64'(word_cnt0), 64'd0);
        check("rst_err_cnt", 64'(err_cnt0), 64'd0);
        check("rst_u1_tx_valid", 64'(tx_valid1), 64'd0);
        reset = 1'b1;
        repeat (3) tick();

        // clean loopback run
        launch0(0);
        start0 = 1'b0;
        tick();
        check("hold_busy", 64'(busy0), 64'd1);
        check("hold_done", 64'(done0), 64'd0);
        check("hold_tx_valid", 64'(tx_valid0), 64'd0);
        wait_done0();
        end_checks("clean");
`ifndef TX_PRBS_EN
        check("first_word_const", 64'(exp_word(DEPTH0, 0)), 64'h0000_0000_FFDD_FFDD);
`endif
        repeat (4) tick();
        check("idle_after_done", 64'(done0), 64'd0);

        // words 5 and 17 corrupted on the way back
        launch0(1);
        start0 = 1'b0;
        wait_done0();
        end_checks("two_err");
        check("two_err_exact", 64'(err_cnt0), 64'd2);
        repeat (4) tick();

        // random corruption
        launch0(2);
        start0 = 1'b0;
        wait_done0();
        end_checks("rand_err");
        repeat (4) tick();

        // reset in the middle of a run
        launch0(0);
        start0 = 1'b0;
        begin
            int n = 0;
            while (sent0 < 10 && n < BUD0) begin tick(); n++; end
            check("reach_word10", 64'(sent0), 64'd10);
        end
        reset = 1'b0;
        tick();
        check("midrst_tx_valid", 64'(tx_valid0), 64'd0);
        check("midrst_busy", 64'(busy0), 64'd0);
        check("midrst_word_cnt", 64'(word_cnt0), 64'd0);
        check("midrst_done", 64'(done0), 64'd0);
        reset = 1'b1;
        clear_pipe();
        repeat (3) tick();
        launch0(0);
        start0 = 1'b0;
        wait_done0();
        end_checks("restart");
        repeat (4) tick();

        // start held high through DONE never relaunches
        launch0(0);
        wait_done0();
        end_checks("held");
        repeat (40) tick();
        check("held_done_stays", 64'(done0), 64'd1);
        check("held_no_relaunch_busy", 64'(busy0), 64'd0);
        check("held_word_cnt", 64'(word_cnt0), 64'(LEN0));
        start0 = 1'b0;
        tick();
        tick();
        check("drop_to_idle_done", 64'(done0), 64'd0);
        check("drop_to_idle_busy", 64'(busy0), 64'd0);
        launch0(0);
        start0 = 1'b0;
        wait_done0();
        end_checks("rerun");
        repeat (4) tick();

        // small instance: DIV=2, DEPTH=1, REPEAT=1, no hold delay
        start1 = 1'b1;
        start_cyc1 = cyc + 1;
        tick();
        start1 = 1'b0;
        begin
            int n = 0;
            while (!done1 && n < 40) begin tick(); n++; end
            check("u1_done", 64'(done1), 64'd1);
        end
        check("u1_latency", 64'(lat1), 64'(DLY1 + DIV1));
        check("u1_valid_cycles", 64'(v1cnt), 64'(LEN1 * DIV1));
        check("u1_first_word", 64'(first1), 64'(exp_word(DEPTH1, 0)));
        check("u1_done_at_fall", 64'(fall_done1), 64'd1);
        check("u1_word_cnt", 64'(word_cnt1), 64'(LEN1));
        repeat (3) tick();
        // garbage on rx while idle must be ignored
        for (int i = 0; i < 10; i++) begin
            rx_valid1 = 1'b1;
            rx_data1  = $urandom();
            tick();
        end
        rx_valid1 = 1'b0;
        tick();
        check("u1_idle_rx_ignored", 64'(err_cnt1), 64'd0);
        check("u1_idle_busy", 64'(busy1), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
